// File: rtl/onehot_rr_arbiter_pkg.sv
// Shared types for the round-robin arbiter: FSM state encoding and one-hot to binary conversion.
package onehot_arb_pkg;

  localparam int MAX_N = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Callers zero-extend their vector to MAX_N bits; the input is assumed one-hot or zero.
  function automatic int unsigned oh2idx(input logic [MAX_N-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_rr_arbiter_if.sv
// Request/ack/grant bundle between requesters, consumer and arbiter; i_lock exists only with ARB_LOCK_EN.
interface onehot_rr_arbiter_if #(
  parameter int N = 4
);
  localparam int IDXW = $clog2(N);

  logic [N-1:0]    i_req;
  logic            i_ack;
`ifdef ARB_LOCK_EN
  logic            i_lock;
`endif
  logic [N-1:0]    o_grant;
  logic [IDXW-1:0] o_grant_idx;
  logic            o_valid;

  modport master (
    output i_req,
    output i_ack,
`ifdef ARB_LOCK_EN
    output i_lock,
`endif
    input  o_grant,
    input  o_grant_idx,
    input  o_valid
  );

  modport slave (
    input  i_req,
    input  i_ack,
`ifdef ARB_LOCK_EN
    input  i_lock,
`endif
    output o_grant,
    output o_grant_idx,
    output o_valid
  );
endinterface

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    grant_o
);

  logic            found;
  logic [IDXW-1:0] pos;
  int              pos_int;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    pos     = '0;
    pos_int = 0;
    for (int k = 0; k < N; k++) begin
      pos_int = int'(ptr_i) + k;
      if (pos_int >= N) pos_int = pos_int - N;
      pos = IDXW'(pos_int);
      if (!found && req_i[pos]) begin
        grant_o[pos] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter producing a registered one-hot mux select, held until ack, then rotated.
// Define ARB_LOCK_EN to add i_lock, which keeps the grant across an ack for burst transfers.
module onehot_rr_arbiter
  import onehot_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input logic              i_clk,
  input logic              i_rst_n,
  onehot_rr_arbiter_if.slave bus
);

  arb_state_e      state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            valid_q;

  logic [N-1:0]     pick_req;
  logic [IDXW-1:0]  pick_ptr;
  logic [N-1:0]     pick_oh;
  logic [IDXW-1:0]  rot_ptr;
  logic             rotate;
  logic [MAX_N-1:0] grant_ext;

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req_i   (pick_req),
    .ptr_i   (pick_ptr),
    .grant_o (pick_oh)
  );

  assign rot_ptr = (idx_q == IDXW'(N - 1)) ? '0 : idx_q + IDXW'(1);

`ifdef ARB_LOCK_EN
  assign rotate = bus.i_ack && !bus.i_lock;
`else
  assign rotate = bus.i_ack;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    pick_req  = bus.i_req;
    pick_ptr  = ptr_q;
    grant_ext = '0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.i_req) begin
          grant_d = pick_oh;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // The just-served source is masked so it only wins again via a fresh IDLE arbitration.
        pick_req = bus.i_req & ~grant_q;
        pick_ptr = rot_ptr;
        if (rotate) begin
          ptr_d   = rot_ptr;
          grant_d = pick_oh;
          state_d = (|pick_oh) ? ST_GRANT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    grant_ext[N-1:0] = grant_d;
    idx_d = IDXW'(oh2idx(grant_ext));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      valid_q <= |grant_d;
    end
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_grant_idx = idx_q;
  assign bus.o_valid     = valid_q;

  a_req_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (valid_q && !bus.i_ack) |-> ((grant_q & ~bus.i_req) == '0));

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Random and directed stimulus against a per-cycle behavioural round-robin model.
module tb_onehot_rr_arbiter;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   m_gnt;
  int   m_ptr;

  onehot_rr_arbiter_if #(.N(N)) bus ();

  onehot_rr_arbiter #(.N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int p);
    int s;
    for (int k = 0; k < N; k++) begin
      s = (p + k) % N;
      if (r[s]) return s;
    end
    return -1;
  endfunction

  // Model advances on each edge from the inputs that were stable at that edge, then checks all outputs.
  always @(posedge clk) begin
    logic [N-1:0] rq;
    logic         ak;
    logic         lk;
    logic [N-1:0] exp_g;
    int           exp_i;
    rq = bus.i_req;
    ak = bus.i_ack;
`ifdef ARB_LOCK_EN
    lk = bus.i_lock;
`else
    lk = 1'b0;
`endif
    if (!rst_n) begin
      m_gnt = -1;
      m_ptr = 0;
    end else if (m_gnt < 0) begin
      if (rq != 0) m_gnt = pick(rq, m_ptr);
    end else if (ak && !lk) begin
      m_ptr = (m_gnt + 1) % N;
      rq[m_gnt] = 1'b0;
      m_gnt = pick(rq, m_ptr);
    end
    exp_g = '0;
    exp_i = 0;
    if (m_gnt >= 0) begin
      exp_g[m_gnt] = 1'b1;
      exp_i = m_gnt;
    end
    #1;
    n_cmp++;
    if (bus.o_grant !== exp_g || int'(bus.o_grant_idx) != exp_i || bus.o_valid !== (m_gnt >= 0)) begin
      n_err++;
      $display("FAIL model t=%0t: grant=%b idx=%0d valid=%b, want grant=%b idx=%0d valid=%b",
               $time, bus.o_grant, bus.o_grant_idx, bus.o_valid, exp_g, exp_i, (m_gnt >= 0));
    end
  end

  task automatic cyc(input logic [N-1:0] r, input logic a, input logic l);
    @(negedge clk);
    bus.i_req = r;
    bus.i_ack = a;
`ifdef ARB_LOCK_EN
    bus.i_lock = l;
`else
    if (l) bus.i_ack = a;
`endif
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [N-1:0] want);
    n_cmp++;
    if (bus.o_grant !== want) begin
      n_err++;
      $display("FAIL %s: grant=%b, want %b", name, bus.o_grant, want);
    end
  endtask

  initial begin
    logic [N-1:0] pend;
    logic [N-1:0] g;
    logic         a;
    logic         l;
    n_cmp = 0;
    n_err = 0;
    m_gnt = -1;
    m_ptr = 0;
    rst_n = 1'b0;
    bus.i_req = 4'b1111;
    bus.i_ack = 1'b0;
`ifdef ARB_LOCK_EN
    bus.i_lock = 1'b0;
`endif
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0);
    lit("reset_idle", 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    cyc(4'b1111, 1'b0, 1'b0);
    lit("reset_release", 4'b0001);

    cyc(4'b1111, 1'b1, 1'b0); lit("rot1", 4'b0010);
    cyc(4'b1111, 1'b1, 1'b0); lit("rot2", 4'b0100);
    cyc(4'b1111, 1'b1, 1'b0); lit("rot3", 4'b1000);
    cyc(4'b1111, 1'b1, 1'b0); lit("rot_wrap", 4'b0001);

    cyc(4'b0001, 1'b1, 1'b0); lit("drain", 4'b0000);
    cyc(4'b0110, 1'b0, 1'b0); lit("hold_first", 4'b0010);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0110, 1'b0, 1'b0);
      lit("hold_stable", 4'b0010);
    end
    cyc(4'b0110, 1'b1, 1'b0); lit("hold_ack", 4'b0100);

    cyc(4'b1110, 1'b1, 1'b0); lit("to_src3", 4'b1000);
    cyc(4'b1000, 1'b1, 1'b0); lit("sole_ack", 4'b0000);
    cyc(4'b1000, 1'b0, 1'b0); lit("sole_regrant", 4'b1000);
    cyc(4'b0000, 1'b1, 1'b0); lit("to_idle", 4'b0000);
    cyc(4'b0000, 1'b1, 1'b0); lit("ack_in_idle", 4'b0000);

    cyc(4'b1000, 1'b0, 1'b0); lit("wrap_setup", 4'b1000);
    cyc(4'b1001, 1'b1, 1'b0); lit("wrap_prio", 4'b0001);
    cyc(4'b0001, 1'b1, 1'b0); lit("wrap_drain", 4'b0000);

`ifdef ARB_LOCK_EN
    cyc(4'b0010, 1'b0, 1'b0); lit("lock_setup", 4'b0010);
    cyc(4'b1111, 1'b1, 1'b1); lit("lock1", 4'b0010);
    cyc(4'b1111, 1'b1, 1'b1); lit("lock2", 4'b0010);
    cyc(4'b1111, 1'b1, 1'b0); lit("lock_end", 4'b0100);
`endif

    // Random phase: each source holds its request until it is granted and acked.
    pend = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 99) != 0);
      pend = pend | N'($urandom_range(0, (1 << N) - 1) & $urandom_range(0, (1 << N) - 1));
      a = ($urandom_range(0, 1) == 1);
      l = ($urandom_range(0, 3) == 0);
      g = bus.o_grant;
      bus.i_req = pend;
      bus.i_ack = a;
`ifdef ARB_LOCK_EN
      bus.i_lock = l;
`else
      l = 1'b0;
`endif
      @(posedge clk);
      if (rst_n && a && !l) pend = pend & ~g;
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

Round-robin arbiter that produces the registered one-hot select driving the one-hot multiplexer stage. It takes N request lines and grants exactly one requester at a time, or none. It holds that grant until the downstream consumer acknowledges the selected transfer, then rotates priority so every requester is eventually served. The grant vector connects directly to the multiplexer's select input, so it is never multi-hot.

## Interface
- N, 4: number of requesters (≥2); select width of the downstream multiplexer.
- IDXW, $clog2(N): width of the binary grant index.
- i_clk  input  1  single clock; all state on the rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_req  input  N  request per source; bit k = source k. A source holds its request until acked.
- i_ack  input  1  consumer accepted the transfer selected by the current grant; meaningful only while o_valid=1.
- i_lock  input  1  present only with ARB_LOCK_EN; keep the current grant across this ack (burst).
- o_grant  output  N  registered one-hot grant (all-zero when idle); drives the mux select.
- o_grant_idx  output  IDXW  binary index of the granted source; 0 when idle.
- o_valid  output  1  high when o_grant is non-zero.

## Operation
- Reset (i_rst_n=0 at an edge):
  - o_grant=0, o_grant_idx=0, o_valid=0, state=IDLE.
  - Priority pointer ptr=0, meaning source 0 has highest priority.
- States: IDLE, GRANT.
- Pick function: the first set bit of i_req, searching from ptr upward with wrap modulo N. The result is one-hot or zero.
- IDLE:
  - If i_req≠0, register pick(i_req, ptr) into o_grant and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - Hold o_grant and o_grant_idx unchanged while i_ack=0. Changes in i_req are ignored.
  - On i_ack=1, set ptr = (o_grant_idx+1) mod N.
  - In the same edge, register pick(i_req & ~o_grant, new ptr).
  - If that pick is non-zero, stay in GRANT with the new grant. There is no bubble.
  - If it is zero, go to IDLE with o_grant=0.
  - A source whose request is still high after its ack is served again only after the others, or on the next arbitration if it is the sole requester.
- i_ack while o_valid=0 is ignored.
- Dropping a granted request before its ack is a protocol violation. The arbiter keeps the grant; an assertion flags it in simulation.
- Wrap-around: ptr at N-1 with source N-1 acked gives ptr=0.
- o_grant_idx always equals the encoded o_grant. o_valid equals |o_grant.

## Timing
- Request to grant: request sampled at edge t in IDLE, grant visible after edge t, 1 cycle.
- Ack to next grant: ack sampled at edge t, next grant visible after edge t, 0 idle cycles between back-to-back grants.
- All outputs are registered. There is no combinational path from i_req or i_ack to o_grant.
- Reset asserted mid-grant clears the outputs at that edge, regardless of i_ack.

## Configuration
- ARB_LOCK_EN defined:
  - The i_lock port exists.
  - On i_ack=1 with i_lock=1, o_grant and ptr are unchanged and the state stays GRANT.
  - The ack with i_lock=0 ends the burst and rotates as normal.
- ARB_LOCK_EN undefined: the i_lock port is absent, and every ack rotates.

## Structure
- Package onehot_arb_pkg holds:
  - the state encoding constants (ST_IDLE, ST_GRANT);
  - the onehot-to-index conversion function.
- Sub-module rr_pick: combinational pick. Inputs are the request vector and ptr; output is the one-hot result. It is instantiated once for the next-grant logic.
- The top module holds the state register, ptr, and the output registers.

## Test plan
All scenarios use N=4.
- Reset: hold i_rst_n=0 with i_req=4'b1111 → o_grant=0000, o_valid=0. Release → o_grant=0001 one cycle later.
- Rotation: i_req=1111 held, i_ack=1 every cycle → o_grant sequence 0001, 0010, 0100, 1000, 0001 with no gaps.
- Hold: i_req=0110, no ack for 5 cycles → o_grant=0010 stable. Ack → 0100 next cycle.
- Sole requester and idle: i_req=1000, ack → grant 1000 reasserted next cycle. Then i_req=0 with ack → o_grant=0000, state IDLE.
- Wrap priority: after granting 1000 and acking with i_req=1001 → next grant is 0001.
- Lock (ARB_LOCK_EN): grant 0010, i_req=1111, two acks with i_lock=1 then one ack with i_lock=0 → 0010 held for both locked acks, then 0100.
